reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file for the five-stage 32-bit MIPS pipeline, replacing the fixed 32x32 file in the ID/WB stages. It provides two combinational read ports and one clocked write port, with r0 hardwired to zero. An integrated scoreboard of busy bits flags read-after-write hazards to the hazard unit. A sequenced clear engine zeroes the file on request without asserting reset.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth `DEPTH = 2**ADDR_W`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk` upstream).
- `rd_addr1`, `rd_addr2` in ADDR_W: read addresses.
- `rd_data1`, `rd_data2` out DATA_W: read data, combinational.
- `hazard1`, `hazard2` out 1: read address is busy (pending write), combinational.
- `wrt_addr` in ADDR_W, `wrt_data` in DATA_W, `wrt_ctrl` in 1: write port.
- `rsv_en` in 1, `rsv_addr` in ADDR_W: reserve a destination (sets its busy bit).
- `clr_req` in 1: request a full clear.
- `clr_busy` out 1: clear sequence in progress.
- `clr_done` out 1: one-cycle pulse when the clear completes.

## Operation
- Reset (`rst`=0):
  - all registers become 0;
  - all busy bits become 0;
  - FSM goes to IDLE;
  - `clr_busy`=0 and `clr_done`=0.
- Reads:
  - `rd_dataN` = `reg[rd_addrN]`;
  - address 0 always returns 0.
- Writes:
  - when `wrt_ctrl`=1 and `wrt_addr`!=0, `reg[wrt_addr]` takes `wrt_data` at the edge;
  - writes to address 0 are dropped.
- Scoreboard:
  - `rsv_en`=1 sets `busy[rsv_addr]` at the edge; address 0 is never set;
  - `wrt_ctrl`=1 clears `busy[wrt_addr]` at the edge;
  - if the same address is reserved and written in the same cycle, the set wins and the bit ends at 1.
- Hazard outputs:
  - `hazardN` = `busy[rd_addrN]`;
  - address 0 always reports no hazard.
- Clear FSM:
  - IDLE: on `clr_req`=1, move to CLEAR, load index=1, zero all busy bits.
  - CLEAR: write 0 to `reg[index]` each cycle and increment index. At index=DEPTH-1, write it, then move to DONE. `clr_busy`=1 throughout CLEAR.
  - DONE: `clr_done`=1 for one cycle, then return to IDLE.
  - While in CLEAR: `wrt_ctrl` and `rsv_en` are ignored, `clr_req` is ignored, and `hazardN` is forced to 1 to stall the pipeline.
- Reset asserted mid-clear aborts the sequence immediately and applies the reset values.

## Timing
- Read latency: 0 cycles (combinational).
- Write: visible to reads in the cycle after the edge, unless bypass is enabled (see Configuration).
- Busy set or clear takes effect in the cycle after the edge.
- Clear duration, from `clr_req` sampled to `clr_done` high:
  - DEPTH-1 cycles in CLEAR, then 1 cycle in DONE;
  - default depth: 31 CLEAR cycles, with `clr_done` in the 32nd cycle after the request edge.
- `clr_busy` rises in the cycle after `clr_req` is sampled and falls when DONE is entered.
- Sampled input data has no other registered latency.

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - when `wrt_ctrl`=1, `wrt_addr`!=0, `wrt_addr`==`rd_addrN` and the FSM is not in CLEAR, `rd_dataN` returns `wrt_data` in the same cycle;
  - `hazardN` is masked to 0 for that port in that cycle.
- `REG_FILE_BYPASS_EN` undefined:
  - reads return the stored value;
  - `hazardN` reflects the busy bit until the edge after the write.

## Structure
- Package `reg_file_pkg` holds:
  - default `DATA_W`/`ADDR_W` constants;
  - the FSM state enumeration (IDLE, CLEAR, DONE).
- One sub-module, `reg_scoreboard`: the DEPTH busy-bit vector with set, clear and flush inputs and two combinational lookup ports.
- The storage array, write logic, bypass and clear FSM live in `reg_file_sb`.

## Test plan
- Reset then read all 32 addresses -> every `rd_data` is 0 and every `hazard` is 0.
- Write 0xDEADBEEF to r5, then read r5 the next cycle -> 0xDEADBEEF. Write 0x12345678 to r0 -> r0 still reads 0.
- Reserve r7, read r7 -> `hazard1`=1. Write r7=0xA5A5A5A5 -> `hazard1`=0 the next cycle. Reserve and write r7 in the same cycle -> `hazard1` stays 1.
- Bypass build: write r9=0xCAFEF00D while `rd_addr2`=9 -> same-cycle `rd_data2`=0xCAFEF00D and `hazard2`=0. Non-bypass build -> old value and `hazard2`=1.
- Fill r1..r31 with nonzero values, pulse `clr_req`:
  - `clr_busy` stays high for 31 cycles;
  - `clr_done` pulses once;
  - all registers read 0 afterwards;
  - a write issued mid-clear is discarded.
- Pull `rst` low at clear cycle 10 -> all outputs return to reset values immediately, and after release the FSM is IDLE.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_pkg: shared widths and clear-engine state encoding.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package reg_file_pkg;

    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_scoreboard: busy bit per register, set/clear/flush, two       |
// | combinational lookups. Rev 1.0                                    |
// +------------------------------------------------------------------+
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_lk_addr1,
    input  logic [ADDR_W-1:0] i_lk_addr2,
    output logic              o_lk_busy1,
    output logic              o_lk_busy2
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set is applied after clear so a same-cycle reserve of the written
    // address leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (i_flush) begin
            busy_d = '0;
        end else begin
            if (i_clr_en) busy_d[i_clr_addr] = 1'b0;
            if (i_set_en) busy_d[i_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign o_lk_busy1 = (i_lk_addr1 != '0) && busy_q[i_lk_addr1];
    assign o_lk_busy2 = (i_lk_addr2 != '0) && busy_q[i_lk_addr2];

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_sb: 2R/1W register file, r0 = 0, busy-bit scoreboard and |
// | sequenced clear. Optional: REG_FILE_BYPASS_EN (write-to-read fwd). |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              hazard1,
    output logic              hazard2,
    input  logic [ADDR_W-1:0] wrt_addr,
    input  logic [DATA_W-1:0] wrt_data,
    input  logic              wrt_ctrl,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned       DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    clr_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic w_in_clear;
    logic w_wr_en;
    logic w_rsv_en;
    logic w_sb_clr;
    logic w_flush;
    logic w_sb_busy1;
    logic w_sb_busy2;
    logic w_byp1;
    logic w_byp2;

    assign w_in_clear = (state_q == ST_CLEAR);
    assign w_wr_en    = wrt_ctrl && !w_in_clear && (wrt_addr != '0);
    assign w_rsv_en   = rsv_en && !w_in_clear;
    assign w_sb_clr   = wrt_ctrl && !w_in_clear;
    assign w_flush    = (state_q == ST_IDLE) && clr_req;

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_rsv_en),
        .i_set_addr (rsv_addr),
        .i_clr_en   (w_sb_clr),
        .i_clr_addr (wrt_addr),
        .i_flush    (w_flush),
        .i_lk_addr1 (rd_addr1),
        .i_lk_addr2 (rd_addr2),
        .o_lk_busy1 (w_sb_busy1),
        .o_lk_busy2 (w_sb_busy2)
    );

    // The clear engine owns the write port while it runs.
    always_comb begin
        regs_d = regs_q;
        if (w_in_clear) begin
            regs_d[idx_q] = '0;
        end else if (w_wr_en) begin
            regs_d[wrt_addr] = wrt_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q    <= ST_CLEAR;
                        idx_q      <= ADDR_W'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (idx_q == c_LAST) begin
                        state_q    <= ST_DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign w_byp1 = w_wr_en && (wrt_addr == rd_addr1);
    assign w_byp2 = w_wr_en && (wrt_addr == rd_addr2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign rd_data1 = w_byp1 ? wrt_data : ((rd_addr1 == '0) ? '0 : regs_q[rd_addr1]);
    assign rd_data2 = w_byp2 ? wrt_data : ((rd_addr2 == '0) ? '0 : regs_q[rd_addr2]);

    // A forwarded operand is already resolved, so its pending busy bit is hidden.
    assign hazard1 = w_in_clear || (w_sb_busy1 && !w_byp1);
    assign hazard2 = w_in_clear || (w_sb_busy2 && !w_byp2);

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_file_sb: directed + random stimulus against an array model |
// | of reg_file_sb. Honours REG_FILE_BYPASS_EN. Rev 1.0               |
// +------------------------------------------------------------------+
module tb_reg_file_sb;

    localparam int NREG = 32;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wrt_addr, rsv_addr;
    logic [31:0] rd_data1, rd_data2, wrt_data;
    logic        hazard1, hazard2, wrt_ctrl, rsv_en, clr_req, clr_busy, clr_done;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .wrt_addr (wrt_addr),
        .wrt_data (wrt_data),
        .wrt_ctrl (wrt_ctrl),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents, busy flags, clear cycles remaining.
    logic [31:0] mem  [NREG];
    bit          busy [NREG];
    int          clr_left;
    bit          exp_done;
    bit          obs_busy, obs_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            mem[i]  = 32'h0;
            busy[i] = 1'b0;
        end
        clr_left = 0;
        exp_done = 1'b0;
    endfunction

    function automatic bit fwd(input logic [4:0] a, input bit wc, input logic [4:0] wa);
        return BYP && (clr_left == 0) && wc && (wa != 5'd0) && (wa == a);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit wc,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (fwd(a, wc, wa)) return wd;
        return mem[a];
    endfunction

    function automatic logic [31:0] exp_haz(input logic [4:0] a, input bit wc, input logic [4:0] wa);
        if (clr_left > 0) return 32'd1;
        if (a == 5'd0 || fwd(a, wc, wa)) return 32'd0;
        return {31'd0, busy[a]};
    endfunction

    task automatic cyc(input bit wc, input logic [4:0] wa, input logic [31:0] wd,
                       input bit re, input logic [4:0] ra, input bit cr,
                       input logic [4:0] a1, input logic [4:0] a2);
        bit idle;
        @(negedge clk);
        wrt_ctrl = wc; wrt_addr = wa; wrt_data = wd;
        rsv_en = re;   rsv_addr = ra; clr_req = cr;
        rd_addr1 = a1; rd_addr2 = a2;
        #1;
        chk("rd_data1", rd_data1, exp_data(a1, wc, wa, wd));
        chk("rd_data2", rd_data2, exp_data(a2, wc, wa, wd));
        chk("hazard1", 32'(hazard1), exp_haz(a1, wc, wa));
        chk("hazard2", 32'(hazard2), exp_haz(a2, wc, wa));
        chk("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
        chk("clr_done", 32'(clr_done), 32'(exp_done));
        obs_busy = clr_busy;
        obs_done = clr_done;
        @(posedge clk);
        if (clr_left > 0) begin
            mem[NREG - clr_left] = 32'h0;
            clr_left--;
            if (clr_left == 0) exp_done = 1'b1;
        end else begin
            idle     = !exp_done;
            exp_done = 1'b0;
            if (wc && wa != 5'd0) mem[wa] = wd;
            if (wc) busy[wa] = 1'b0;
            if (re && ra != 5'd0) busy[ra] = 1'b1;
            if (idle && cr) begin
                for (int i = 0; i < NREG; i++) busy[i] = 1'b0;
                clr_left = NREG - 1;
            end
        end
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a1, a2);
    endtask

    task automatic read_all();
        for (int i = 0; i < NREG / 2; i++) idle_read(5'(2 * i), 5'(2 * i + 1));
    endtask

    task automatic fill_all();
        for (int i = 1; i < NREG; i++)
            cyc(1'b1, 5'(i), $urandom | 32'h1, (i % 3) == 0, 5'(NREG - i), 1'b0,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endtask

    initial begin
        int busy_cnt, done_cnt;
        rst = 1'b0;
        wrt_ctrl = 1'b0; wrt_addr = '0; wrt_data = '0;
        rsv_en = 1'b0;   rsv_addr = '0; clr_req = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd31;
        model_reset();

        // In reset
        repeat (2) @(negedge clk);
        #1;
        chk("reset_clr_busy", 32'(clr_busy), 32'd0);
        chk("reset_clr_done", 32'(clr_done), 32'd0);
        chk("reset_rd_data1", rd_data1, 32'h0);
        chk("reset_hazard2", 32'(hazard2), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        read_all();

        // Basic write, r0 write dropped
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        idle_read(5'd5, 5'd0);
        cyc(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd5);

        // Scoreboard: reserve, write-release, reserve+write same cycle
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        idle_read(5'd7, 5'd7);
        cyc(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7);
        cyc(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        idle_read(5'd7, 5'd7);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0);

        // Same-cycle write/read of a reserved register
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
        cyc(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
        idle_read(5'd9, 5'd9);

        // Full clear, with a write, a reserve and a clr_req issued mid-clear
        fill_all();
        busy_cnt = 0;
        done_cnt = 0;
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd30);
        for (int k = 0; k < 34; k++) begin
            if (k == 15)
                cyc(1'b1, 5'd3, 32'h0BADF00D, 1'b1, 5'd4, 1'b1, 5'd3, 5'd4);
            else
                idle_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            busy_cnt += int'(obs_busy);
            done_cnt += int'(obs_done);
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd31);
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        idle_read(5'd3, 5'd4);
        chk("mid_clear_write_dropped", rd_data1, 32'h0);
        chk("mid_clear_rsv_dropped", 32'(hazard2), 32'd0);
        read_all();

        // Reset mid-clear at clear cycle 10
        fill_all();
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
        for (int k = 0; k < 10; k++) idle_read(5'd20, 5'd25);
        @(negedge clk);
        rd_addr1 = 5'd20; rd_addr2 = 5'd25;
        #2 rst = 1'b0;
        #1;
        chk("abort_clr_busy", 32'(clr_busy), 32'd0);
        chk("abort_clr_done", 32'(clr_done), 32'd0);
        chk("abort_rd_data1", rd_data1, 32'h0);
        chk("abort_rd_data2", rd_data2, 32'h0);
        chk("abort_hazard1", 32'(hazard1), 32'd0);
        chk("abort_hazard2", 32'(hazard2), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 5'd20, 32'h5EED5EED, 1'b0, 5'd0, 1'b0, 5'd20, 5'd0);
        idle_read(5'd20, 5'd25);
        read_all();

        // Random traffic
        for (int n = 0; n < 500; n++)
            cyc($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                $urandom_range(0, 59) == 0,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        for (int n = 0; n < 40; n++) idle_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
